// File: rtl/truth_sweep_pkg.sv
// rtl/truth_sweep_pkg.sv - shared state encoding and sizing helpers for the truth-table sweeper
package truth_sweep_pkg;

  localparam int DEFAULT_NUM_IN = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  function automatic int num_vectors(input int num_in);
    return 1 << num_in;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter that times the settle wait after each vector
module settle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero so a late decrement request cannot wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks every input vector of a gate, captures its outputs and grades them
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [CNT_W-1:0]               settle_cycles,
  input  logic [num_vectors(NUM_IN)-1:0] expected,
  output logic                           in1,
  output logic                           in2,
  output logic                           in3,
  input  logic                           gate_out,
  output logic                           busy,
  output logic                           done,
  output logic [num_vectors(NUM_IN)-1:0] truth_table,
  output logic                           match,
  output logic [NUM_IN-1:0]              first_fail
);

  localparam int VEC = num_vectors(NUM_IN);
  localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(VEC - 1);

  state_t            state;
  logic [NUM_IN-1:0] idx;
  logic [CNT_W-1:0]  settle_reg;
  logic [VEC-1:0]    table_next;
  logic [NUM_IN-1:0] ff_next;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [2:0]        vec;

  always_comb begin
    cnt_load     = !abort && (((state == IDLE) && start) ||
                              ((state == SAMPLE) && (idx != LAST_IDX)));
    cnt_load_val = (state == IDLE) ? settle_cycles : settle_reg;
    cnt_dec      = !abort && (state == SETTLE);
  end

  settle_counter #(.CNT_W(CNT_W)) u_settle_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Grading uses the table including the final sample so match is valid with done.
  always_comb begin
    table_next      = truth_table;
    table_next[idx] = gate_out;
    ff_next         = '0;
    for (int i = VEC - 1; i >= 0; i--) begin
      if (table_next[i] != expected[i]) begin
        ff_next = NUM_IN'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      settle_reg  <= '0;
      truth_table <= '0;
      match       <= 1'b0;
      first_fail  <= '0;
      done        <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      match <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            settle_reg  <= settle_cycles;
            idx         <= '0;
            truth_table <= '0;
            match       <= 1'b0;
            first_fail  <= '0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          truth_table <= table_next;
          if (idx == LAST_IDX) begin
            state      <= FINISH;
            done       <= 1'b1;
            match      <= (table_next == expected);
            first_fail <= ff_next;
          end else begin
            idx   <= idx + 1'b1;
            state <= SETTLE;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign vec             = 3'(idx);
  assign {in1, in2, in3} = vec;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized and directed bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] settle_cycles = 8'd0;
  logic [7:0] expected = 8'd0;
  logic       in1, in2, in3;
  logic       gate_out;
  logic       busy, done;
  logic [7:0] truth_table;
  logic       match;
  logic [2:0] first_fail;
  logic [7:0] gate_tt = 8'hB0;

  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;
  bit chk_en = 1'b0;

  // Sweep-level reference: position in the sweep is derived from cycles since start.
  bit         m_busy, m_done, m_match;
  int         m_k, m_s, m_idx;
  logic [7:0] m_table;
  logic [2:0] m_ff;

  truth_table_sweeper #(.NUM_IN(3), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .settle_cycles (settle_cycles),
    .expected      (expected),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .gate_out      (gate_out),
    .busy          (busy),
    .done          (done),
    .truth_table   (truth_table),
    .match         (match),
    .first_fail    (first_fail)
  );

  assign gate_out = gate_tt[{in1, in2, in3}];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] low_mask(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] first_diff(input logic [7:0] t, input logic [7:0] e);
    for (int i = 0; i < 8; i++) if (t[i] != e[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_match = 0;
    m_k = 0; m_s = 0; m_idx = 0;
    m_table = '0; m_ff = '0;
  endtask

  task automatic model_update();
    int k, per, len, nsamp;
    if (rst) begin model_reset(); return; end
    if (abort) begin
      m_busy = 0; m_k = 0; m_idx = 0; m_done = 0; m_match = 0;
      return;
    end
    if (!m_busy) begin
      m_done = 0;
      if (start) begin
        m_busy = 1; m_k = 1; m_s = int'(settle_cycles);
        m_table = '0; m_match = 0; m_ff = '0; m_idx = 0;
      end
      return;
    end
    k = m_k + 1;
    per = m_s + 2;
    len = 8 * per;
    if (k > len + 1) begin
      m_busy = 0; m_done = 0; m_k = 0;
      return;
    end
    m_k = k;
    nsamp = (k - 1) / per;
    m_idx = (nsamp > 7) ? 7 : nsamp;
    m_table = gate_tt & low_mask(nsamp);
    m_done = (k == len + 1);
    if (m_done) begin
      m_match = (m_table == expected);
      m_ff = first_diff(m_table, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (done === 1'b1) done_count++;
  endtask

  task automatic launch(input logic [7:0] s);
    settle_cycles = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int from, input int limit, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("vector", 32'({in1, in2, in3}), 32'(m_idx));
      check("table", 32'(truth_table), 32'(m_table));
      check("match", 32'(match), 32'(m_match));
      check("first_fail", 32'(first_fail), 32'(m_ff));
    end
  end

  initial begin
    int cyc;
    int dc0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vector", 32'({in1, in2, in3}), 32'd0);
    check("rst_table", 32'(truth_table), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_first_fail", 32'(first_fail), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(); tick();

    gate_tt = 8'hB0; expected = 8'hB0;
    launch(8'd0);
    run_to_done(1, 100, cyc);
    check("s1_latency", 32'(cyc), 32'd17);
    check("s1_table", 32'(truth_table), 32'hB0);
    check("s1_match", 32'(match), 32'd1);
    check("s1_first_fail", 32'(first_fail), 32'd0);
    tick();
    check("s1_idle_vector", 32'({in1, in2, in3}), 32'd7);
    check("s1_hold_match", 32'(match), 32'd1);

    expected = 8'hB4;
    launch(8'd3);
    run_to_done(1, 200, cyc);
    check("s2_latency", 32'(cyc), 32'd41);
    check("s2_table", 32'(truth_table), 32'hB0);
    check("s2_match", 32'(match), 32'd0);
    check("s2_first_fail", 32'(first_fail), 32'd2);

    tick();
    expected = 8'hB0;
    dc0 = done_count;
    launch(8'd2);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s3_abort_busy", 32'(busy), 32'd0);
    check("s3_abort_vector", 32'({in1, in2, in3}), 32'd0);
    check("s3_abort_match", 32'(match), 32'd0);
    check("s3_no_done", 32'(done_count - dc0), 32'd0);
    tick();
    launch(8'd2);
    run_to_done(1, 200, cyc);
    check("s3_restart_latency", 32'(cyc), 32'd33);
    check("s3_restart_match", 32'(match), 32'd1);

    tick();
    dc0 = done_count;
    launch(8'd1);
    repeat (17) tick();
    check("s4_sample_vector", 32'({in1, in2, in3}), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_done", 32'(done), 32'd0);
    check("s4_rst_vector", 32'({in1, in2, in3}), 32'd0);
    check("s4_rst_table", 32'(truth_table), 32'd0);
    check("s4_rst_match", 32'(match), 32'd0);
    check("s4_rst_first_fail", 32'(first_fail), 32'd0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("s4_no_done", 32'(done_count - dc0), 32'd0);
    launch(8'd1);
    run_to_done(1, 200, cyc);
    check("s4_restart_latency", 32'(cyc), 32'd25);
    check("s4_restart_table", 32'(truth_table), 32'hB0);

    tick();
    dc0 = done_count;
    launch(8'd2);
    repeat (4) tick();
    start = 1'b1; settle_cycles = 8'd0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1; settle_cycles = 8'd7;
    tick();
    start = 1'b0;
    run_to_done(17, 200, cyc);
    check("s5_latency", 32'(cyc), 32'd33);
    repeat (3) tick();
    check("s5_one_done", 32'(done_count - dc0), 32'd1);

    dc0 = done_count;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("s6_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("s6_busy_later", 32'(busy), 32'd0);
    check("s6_no_done", 32'(done_count - dc0), 32'd0);

    for (int n = 0; n < 25; n++) begin
      gate_tt = 8'($urandom);
      expected = ($urandom_range(0, 1) == 1) ? gate_tt : gate_tt ^ 8'(1 << $urandom_range(0, 7));
      launch(8'($urandom_range(0, 3)));
      for (int c = 0; c < 120 && m_busy; c++) begin
        abort = ($urandom_range(0, 59) == 0);
        start = ($urandom_range(0, 7) == 0);
        settle_cycles = 8'($urandom);
        tick();
      end
      abort = 1'b0; start = 1'b0;
      check("rand_sweep_ended", 32'(busy), 32'd0);
      tick(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
